// File: rtl/wb_gpio_pkg.sv
// Shared constants, bus FSM states and byte-lane helper for the GPIO bank.
package wb_gpio_pkg;

  localparam int unsigned DW     = 32;
  localparam int unsigned SELW   = DW / 8;
  localparam int unsigned OFFW   = 3;
  localparam int unsigned CHW    = 3;

  localparam logic [DW-1:0] CH_STRIDE = 32'h0000_0020;

  localparam logic [OFFW-1:0] OFF_OUT  = 3'd0;
  localparam logic [OFFW-1:0] OFF_OE   = 3'd1;
  localparam logic [OFFW-1:0] OFF_IN   = 3'd2;
  localparam logic [OFFW-1:0] OFF_IE   = 3'd3;
  localparam logic [OFFW-1:0] OFF_EDGE = 3'd4;
  localparam logic [OFFW-1:0] OFF_IP   = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_e;

  // Replace the bytes of old_v selected by sel with the matching bytes of new_v.
  function automatic logic [DW-1:0] apply_sel(input logic [DW-1:0]   old_v,
                                              input logic [DW-1:0]   new_v,
                                              input logic [SELW-1:0] sel);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(SELW); b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/gpio_channel.sv
// One 32-bit GPIO channel: control registers, input synchroniser, edge-detect interrupts.
module gpio_channel
  import wb_gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [OFFW-1:0] off,
  input  logic [DW-1:0]   wr_data,
  input  logic [SELW-1:0] wr_sel,
  input  logic [DW-1:0]   gpio_i,
  output logic [DW-1:0]   gpio_o,
  output logic [DW-1:0]   gpio_oe_o,
  output logic [DW-1:0]   rd_data_c,
  output logic            irq_term_c
);

  logic [DW-1:0] sync_q [SYNC_STAGES];
  logic [DW-1:0] hist_q;
  logic [DW-1:0] ie_q;
  logic [DW-1:0] edge_q;
  logic [DW-1:0] ip_q;
  logic [DW-1:0] in_c;
  logic [DW-1:0] event_c;
  logic [DW-1:0] w1c_mask_c;

  assign in_c       = sync_q[SYNC_STAGES-1];
  assign event_c    = (edge_q & ~in_c & hist_q) | (~edge_q & in_c & ~hist_q);
  assign w1c_mask_c = (wr_en && off == OFF_IP) ? apply_sel('0, wr_data, wr_sel) : '0;
  assign irq_term_c = |(ip_q & ie_q);

  // Pad synchroniser chain followed by the edge-history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= gpio_i;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      hist_q <= in_c;
    end
  end

  // Control registers; a same-cycle edge event beats a W1C clear on IP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_o    <= '0;
      gpio_oe_o <= '0;
      ie_q      <= '0;
      edge_q    <= '0;
      ip_q      <= '0;
    end else begin
      ip_q <= (ip_q & ~w1c_mask_c) | event_c;
      if (wr_en) begin
        case (off)
          OFF_OUT:  gpio_o    <= apply_sel(gpio_o, wr_data, wr_sel);
          OFF_OE:   gpio_oe_o <= apply_sel(gpio_oe_o, wr_data, wr_sel);
          OFF_IE:   ie_q      <= apply_sel(ie_q, wr_data, wr_sel);
          OFF_EDGE: edge_q    <= apply_sel(edge_q, wr_data, wr_sel);
          default:  ;
        endcase
      end
    end
  end

  // Register read selection.
  always_comb begin
    rd_data_c = '0;
    case (off)
      OFF_OUT:  rd_data_c = gpio_o;
      OFF_OE:   rd_data_c = gpio_oe_o;
      OFF_IN:   rd_data_c = in_c;
      OFF_IE:   rd_data_c = ie_q;
      OFF_EDGE: rd_data_c = edge_q;
      OFF_IP:   rd_data_c = ip_q;
      default:  rd_data_c = '0;
    endcase
  end

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone B4 classic slave fronting NCH GPIO channels with a combined interrupt.
module wb_gpio_bank
  import wb_gpio_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter logic [31:0] GPIO_BASE   = 32'h1001_0000,
  parameter logic [31:0] GPIO_MASK   = 32'hFFFF_F000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic [32*NCH-1:0] gpio_o,
  output logic [32*NCH-1:0] gpio_oe_o,
  input  logic [32*NCH-1:0] gpio_i,
  output logic              irq_o
);

  bus_state_e       state_q;
  logic             req_c;
  logic             valid_c;
  logic [CHW-1:0]   ch_c;
  logic [OFFW-1:0]  off_c;
  logic [DW-1:0]    rd_c;
  logic [DW-1:0]    ch_rdata [NCH];
  logic [NCH-1:0]   irq_term;

  assign req_c   = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign ch_c    = wb_adr_i[7:5];
  assign off_c   = wb_adr_i[4:2];
  assign valid_c = ((wb_adr_i & GPIO_MASK) == GPIO_BASE)
                 && (32'(ch_c) < NCH)
                 && (off_c <= OFF_IP);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gpio_channel #(.SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .wr_en      (req_c & valid_c & wb_we_i & (ch_c == CHW'(c))),
      .off        (off_c),
      .wr_data    (wb_dat_i),
      .wr_sel     (wb_sel_i),
      .gpio_i     (gpio_i[32*c +: 32]),
      .gpio_o     (gpio_o[32*c +: 32]),
      .gpio_oe_o  (gpio_oe_o[32*c +: 32]),
      .rd_data_c  (ch_rdata[c]),
      .irq_term_c (irq_term[c])
    );
  end

  // Read mux across channels.
  always_comb begin
    rd_c = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (ch_c == CHW'(c)) rd_c = ch_rdata[c];
    end
  end

  // Bus response FSM with registered ack/err/data and the combined irq.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      irq_o    <= |irq_term;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      case (state_q)
        IDLE: begin
          if (req_c) begin
            state_q <= RESP;
            if (valid_c) begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= wb_we_i ? '0 : rd_c;
            end else begin
              wb_err_o <= 1'b1;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
